rs_syndrome: RTL and testbench
==============================

Name: rs_syndrome

Overview:
- Byte-serial Reed-Solomon front end over GF(2^8) with 4 check symbols.
- Encoding mode: computes 4 parity bytes over a data segment, then shifts them out on dataO.
- Decoding mode: computes syndromes S0..S3 over a received segment and hands them to the downstream RS error locator/evaluator with a one-cycle synReady strobe.
- Sits between the flash byte stream and the RS solver.

Parameters:
- none. Field, code and polynomials are fixed:
  - Field polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
  - Generator g(x) = (x+a^0)(x+a^1)(x+a^2)(x+a^3) = x^4 + 0x0F x^3 + 0x36 x^2 + 0x78 x + 0x40.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- running  in  1  block enable; 0 = idle, all accumulators cleared.
- encoding  in  1  1 = encode mode, 0 = decode mode.
- endSegment  in  1  qualifies the current valid byte as the last byte of the segment.
- dataI  in  8  input byte.
- valid  in  1  one-cycle byte strobe.
- blanking  in  1  byte excluded from the code computation (treated as 0x00).
- s0  out  8  syndrome S0 = r(a^0).
- s1  out  8  syndrome S1 = r(a^1).
- s2  out  8  syndrome S2 = r(a^2).
- s3  out  8  syndrome S3 = r(a^3).
- synReady  out  1  one-cycle pulse: s0..s3 updated.
- dataO  out  8  registered output byte (pass-through or parity).

Behaviour:
- Reset (reset=1 at a clock edge):
  - s0..s3, dataO, synReady, all LFSR/accumulator registers and the parity counter go to 0.
  - State goes to DATA.
  - Reset has priority over every other input.
- running=0: same clearing as reset, except s0..s3 hold their last values. Valid is ignored. Deasserting running mid-segment abandons the segment.
- Byte accepted = rising edge with running=1 and valid=1. Effective byte b = blanking ? 0x00 : dataI.
- Polynomial order: codeword bytes enter highest degree first (first byte = highest coefficient).
- Encode mode, DATA state (encoding=1), per accepted byte:
  - fb = b ^ p3.
  - p3 <= p2 ^ 0x0F*fb; p2 <= p1 ^ 0x36*fb; p1 <= p0 ^ 0x78*fb; p0 <= 0x40*fb.
  - Multiplies are GF(2^8) mod 0x11D.
  - dataO <= dataI (raw byte, even if blanked).
  - If endSegment=1, go to PARITY.
- Encode mode, PARITY state: each accepted byte (dataI ignored) loads dataO with the next parity byte, in order p3, p2, p1, p0.
  - The byte is visible on dataO immediately after the accepting edge.
  - After the 4th, clear the LFSR and return to DATA.
  - endSegment is ignored in PARITY.
- Decode mode (encoding=0), per accepted byte:
  - Si <= Si*a^i ^ b, for i = 0..3 (multipliers 0x01, 0x02, 0x04, 0x08).
  - dataO <= dataI.
- Decode mode, endSegment=1 on an accepted byte:
  - On that edge, s0..s3 outputs load the final values (including this byte).
  - synReady=1 for exactly the following cycle.
  - Accumulators clear for the next segment.
- s0..s3 hold until the next synReady.
- No synReady is ever generated in encode mode.
- Mode is sampled per byte. Changing encoding mid-segment is illegal; the design clears state when encoding toggles.
- valid with no endSegment between segments simply accumulates.
- Segment length is unconstrained (nominally 172 data + 4 parity = 176 bytes).
- Latency: dataO is 1 cycle after acceptance; synReady is 1 cycle after the final byte.
- Back-to-back valid (every cycle) is supported.

Test Plan:
- Encode one byte 0x01 with endSegment=1, then 4 valid strobes -> dataO = 0x0F, 0x36, 0x78, 0x40.
- Decode 0x01, 0x0F, 0x36, 0x78, 0x40 with endSegment on the last byte -> s0..s3 = 0x00 and synReady pulses for 1 cycle.
- Decode 0x01, 0x00 (endSegment on the 2nd byte) -> s0=0x01, s1=0x02, s2=0x04, s3=0x08.
- Decode 0xFF (blanking=1), 0x01 (end) -> s0..s3 = 0x01 each; dataO echoes 0xFF then 0x01.
- Encode 172 bytes of ~i, take 4 parity bytes, then decode all 176 -> all syndromes 0. Flipping byte 100 by 0x08 -> s0 = 0x08, other syndromes nonzero.
- Deassert running mid-segment, then run a fresh 1-byte 0x01 decode -> s0..s3 = 0x01 (no residue from the abandoned segment). Reset mid-PARITY -> dataO = 0 and the next encode starts clean.

Source files
------------

// File: rtl/rs_syndrome.sv
// rs_syndrome: byte-serial Reed-Solomon front end over GF(2^8), 4 check symbols.
//   Field polynomial 0x11D, alpha = 0x02,
//   g(x) = x^4 + 0x0F x^3 + 0x36 x^2 + 0x78 x + 0x40.
//   Encode mode: LFSR parity over a data segment, then parity shifted out on dataO.
//   Decode mode: syndromes S0..S3 accumulated per segment, published with synReady.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   running          - block enable; 0 clears all working state (s0..s3 hold)
//   encoding         - 1 = encode, 0 = decode
//   endSegment       - current valid byte is the last of the segment
//   dataI, valid     - input byte and its one-cycle strobe
//   blanking         - byte counts as 0x00 in the code computation
//   s0..s3           - syndromes r(a^0)..r(a^3)
//   synReady         - one-cycle pulse when s0..s3 update
//   dataO            - registered pass-through byte or parity byte
module rs_syndrome (
  input  logic       clk,
  input  logic       reset,
  input  logic       running,
  input  logic       encoding,
  input  logic       endSegment,
  input  logic [7:0] dataI,
  input  logic       valid,
  input  logic       blanking,
  output logic [7:0] s0,
  output logic [7:0] s1,
  output logic [7:0] s2,
  output logic [7:0] s3,
  output logic       synReady,
  output logic [7:0] dataO
);

  typedef enum logic {DATA, PARITY} state_t;

  localparam logic [3:0][7:0] ALPHA_POW = {8'h08, 8'h04, 8'h02, 8'h01};

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return acc;
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [3:0][7:0] p_q, p_d;       // parity LFSR, p[3] is highest degree
  logic [3:0][7:0] acc_q, acc_d;   // syndrome accumulators
  logic [3:0][7:0] syn_q, syn_d;   // published syndromes
  logic            syn_rdy_q, syn_rdy_d;
  logic [7:0]      data_o_q, data_o_d;
  logic            enc_q, enc_d;

  logic [7:0]      b;
  logic [7:0]      fb;
  logic [3:0][7:0] acc_next;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    acc_d     = acc_q;
    syn_d     = syn_q;
    syn_rdy_d = 1'b0;
    data_o_d  = data_o_q;
    enc_d     = encoding;
    fb        = '0;
    acc_next  = '0;
    b         = blanking ? 8'h00 : dataI;

    if (!running) begin
      state_d  = DATA;
      cnt_d    = '0;
      p_d      = '0;
      acc_d    = '0;
      data_o_d = '0;
    end else begin
      // A mode change starts from clean state; the byte on the same edge is
      // then processed in the new mode against that cleared state.
      if (encoding != enc_q) begin
        state_d = DATA;
        cnt_d   = '0;
        p_d     = '0;
        acc_d   = '0;
      end
      if (valid) begin
        if (encoding) begin
          if (state_d == DATA) begin
            fb       = b ^ p_d[3];
            p_d      = {p_d[2] ^ gf_mul(fb, 8'h0F),
                        p_d[1] ^ gf_mul(fb, 8'h36),
                        p_d[0] ^ gf_mul(fb, 8'h78),
                        gf_mul(fb, 8'h40)};
            data_o_d = dataI;
            if (endSegment) state_d = PARITY;
          end else begin
            // Shifting the LFSR out leaves it all-zero after the 4th byte.
            data_o_d = p_d[3];
            p_d      = {p_d[2:0], 8'h00};
            if (cnt_d == 2'd3) begin
              state_d = DATA;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_d + 2'd1;
            end
          end
        end else begin
          for (int unsigned i = 0; i < 4; i++) begin
            acc_next[i] = gf_mul(acc_d[i], ALPHA_POW[i]) ^ b;
          end
          data_o_d = dataI;
          if (endSegment) begin
            syn_d     = acc_next;
            syn_rdy_d = 1'b1;
            acc_d     = '0;
          end else begin
            acc_d = acc_next;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= DATA;
      cnt_q     <= '0;
      p_q       <= '0;
      acc_q     <= '0;
      syn_q     <= '0;
      syn_rdy_q <= 1'b0;
      data_o_q  <= '0;
      enc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      acc_q     <= acc_d;
      syn_q     <= syn_d;
      syn_rdy_q <= syn_rdy_d;
      data_o_q  <= data_o_d;
      enc_q     <= enc_d;
    end
  end

  assign s0       = syn_q[0];
  assign s1       = syn_q[1];
  assign s2       = syn_q[2];
  assign s3       = syn_q[3];
  assign synReady = syn_rdy_q;
  assign dataO    = data_o_q;

endmodule

// File: tb/tb_rs_syndrome.sv
module tb_rs_syndrome;

  logic       clk = 1'b0;
  logic       reset, running, encoding, endSegment, valid, blanking;
  logic [7:0] dataI;
  logic [7:0] s0, s1, s2, s3, dataO;
  logic       synReady;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] gexp [256];
  int         glog [256];
  logic [7:0] cw [176];
  logic [7:0] r [4];

  always #5 clk = ~clk;

  rs_syndrome dut (
    .clk(clk), .reset(reset), .running(running), .encoding(encoding),
    .endSegment(endSegment), .dataI(dataI), .valid(valid), .blanking(blanking),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .synReady(synReady), .dataO(dataO)
  );

  // GF(2^8) multiply via log/antilog tables built from repeated xtime.
  function automatic logic [7:0] tmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic e, input logic bl);
    valid = 1'b1; dataI = d; endSegment = e; blanking = bl;
    @(posedge clk); #1;
    valid = 1'b0; endSegment = 1'b0; blanking = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic chk_syn(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    chk({tag, "_s0"}, s0, e0);
    chk({tag, "_s1"}, s1, e1);
    chk({tag, "_s2"}, s2, e2);
    chk({tag, "_s3"}, s3, e3);
  endtask

  initial begin
    logic [7:0] e, fb, d;
    e = 8'h01;
    for (int k = 0; k < 255; k++) begin
      gexp[k] = e;
      glog[e] = k;
      e = {e[6:0], 1'b0} ^ (e[7] ? 8'h1D : 8'h00);
    end

    reset = 1'b1; running = 1'b0; encoding = 1'b0; endSegment = 1'b0;
    valid = 1'b0; blanking = 1'b0; dataI = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_syn("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("rst_dataO", dataO, 8'h00);
    chk("rst_synReady", {7'd0, synReady}, 8'h00);
    reset = 1'b0; running = 1'b1;
    idle();

    // Encode single byte 0x01: parity equals the low coefficients of g(x).
    encoding = 1'b1;
    send(8'h01, 1'b1, 1'b0);
    chk("enc1_echo", dataO, 8'h01);
    send(8'hAA, 1'b0, 1'b0); chk("enc1_p3", dataO, 8'h0F);
    send(8'hAA, 1'b1, 1'b0); chk("enc1_p2", dataO, 8'h36);
    send(8'hAA, 1'b0, 1'b0); chk("enc1_p1", dataO, 8'h78);
    send(8'hAA, 1'b0, 1'b0); chk("enc1_p0", dataO, 8'h40);
    chk("enc_no_synReady", {7'd0, synReady}, 8'h00);
    send(8'h5A, 1'b0, 1'b0); chk("enc1_back_to_data", dataO, 8'h5A);
    idle();

    // Decode g(x) itself: a codeword, so all syndromes are zero.
    encoding = 1'b0;
    send(8'h01, 1'b0, 1'b0);
    send(8'h0F, 1'b0, 1'b0);
    send(8'h36, 1'b0, 1'b0);
    send(8'h78, 1'b0, 1'b0);
    send(8'h40, 1'b1, 1'b0);
    chk("dec_g_synReady", {7'd0, synReady}, 8'h01);
    chk_syn("dec_g", 8'h00, 8'h00, 8'h00, 8'h00);
    idle();
    chk("dec_g_synReady_drop", {7'd0, synReady}, 8'h00);

    // r(x) = x  ->  S_i = a^i
    send(8'h01, 1'b0, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    chk_syn("dec_x", 8'h01, 8'h02, 8'h04, 8'h08);
    idle();

    // Blanked 0xFF counts as zero but is still echoed.
    send(8'hFF, 1'b0, 1'b1);
    chk("blank_echo", dataO, 8'hFF);
    chk_syn("blank_hold", 8'h01, 8'h02, 8'h04, 8'h08);
    send(8'h01, 1'b1, 1'b0);
    chk("blank_echo2", dataO, 8'h01);
    chk_syn("blank", 8'h01, 8'h01, 8'h01, 8'h01);
    idle();

    // 172-byte encode of ~i against a table-based LFSR model.
    for (int k = 0; k < 4; k++) r[k] = 8'h00;
    for (int i = 0; i < 172; i++) begin
      d = ~i[7:0];
      cw[i] = d;
      fb = d ^ r[3];
      r[3] = r[2] ^ tmul(fb, 8'h0F);
      r[2] = r[1] ^ tmul(fb, 8'h36);
      r[1] = r[0] ^ tmul(fb, 8'h78);
      r[0] = tmul(fb, 8'h40);
    end
    cw[172] = r[3]; cw[173] = r[2]; cw[174] = r[1]; cw[175] = r[0];
    encoding = 1'b1;
    for (int i = 0; i < 172; i++) send(cw[i], (i == 171), 1'b0);
    chk("long_last_echo", dataO, cw[171]);
    for (int k = 0; k < 4; k++) begin
      send(8'h00, 1'b0, 1'b0);
      chk($sformatf("long_parity%0d", k), dataO, cw[172 + k]);
    end
    idle();

    encoding = 1'b0;
    for (int i = 0; i < 176; i++) send(cw[i], (i == 175), 1'b0);
    chk("long_synReady", {7'd0, synReady}, 8'h01);
    chk_syn("long_clean", 8'h00, 8'h00, 8'h00, 8'h00);
    idle();

    // Error 0x08 at byte 100 -> degree 75: S_i = 0x08 * a^(75 i).
    for (int i = 0; i < 176; i++) send((i == 100) ? (cw[i] ^ 8'h08) : cw[i], (i == 175), 1'b0);
    chk_syn("long_err", 8'h08, tmul(8'h08, gexp[75]), tmul(8'h08, gexp[150]),
            tmul(8'h08, gexp[225 % 255]));
    idle();

    // Abandon a segment with running=0; syndromes hold, working state clears.
    send(8'h55, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    running = 1'b0;
    idle();
    chk("norun_dataO", dataO, 8'h00);
    chk("norun_s0_hold", s0, 8'h08);
    running = 1'b1;
    send(8'h01, 1'b1, 1'b0);
    chk_syn("abandon", 8'h01, 8'h01, 8'h01, 8'h01);
    idle();

    // Reset mid-PARITY, then a clean encode.
    encoding = 1'b1;
    send(8'h01, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    chk("midpar_p3", dataO, 8'h0F);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("midpar_rst_dataO", dataO, 8'h00);
    chk_syn("midpar_rst", 8'h00, 8'h00, 8'h00, 8'h00);
    send(8'h01, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b0); chk("re_p3", dataO, 8'h0F);
    send(8'h00, 1'b0, 1'b0); chk("re_p2", dataO, 8'h36);
    send(8'h00, 1'b0, 1'b0); chk("re_p1", dataO, 8'h78);
    send(8'h00, 1'b0, 1'b0); chk("re_p0", dataO, 8'h40);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
